// File: rtl/key_puzzle_engine.sv
// Key puzzle engine: synchronized key presses transform an LED state toward a defuse target.
// Optional countdown timer enabled by defining KEY_PUZZLE_TIMER_EN.
module key_puzzle_engine #(
    parameter int               WIDTH      = 8,
    parameter int               NKEYS      = 5,
    parameter logic [WIDTH-1:0] INIT       = WIDTH'(8'h5A),
    parameter logic [WIDTH-1:0] TARGET     = WIDTH'(8'hFF),
    parameter logic [WIDTH-1:0] PATTERN    = WIDTH'(8'h03),
    parameter int               MAX_MOVES  = 16,
    parameter int               TIME_LIMIT = 1000
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [NKEYS-1:0] K,
    input  logic             DifMod,
    output logic [WIDTH-1:0] LED,
    output logic             isd,
    output logic             fail,
    output logic [1:0]       op,
    output logic [7:0]       moves,
    output logic [15:0]      time_left
);

    typedef enum logic [1:0] {S_PLAY, S_DEFUSED, S_FAILED} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [NKEYS-1:0] r_k_meta;
    logic [NKEYS-1:0] r_k_sync;
    logic [NKEYS-1:0] r_k_prev;
    logic [WIDTH-1:0] r_led;
    logic [1:0]       r_op;
    logic [7:0]       r_moves;
    logic [NKEYS-1:0] w_valid;
    logic [2:0]       w_sel;
    logic [3:0]       w_rot;
    logic [WIDTH-1:0] w_opd;
    logic [WIDTH-1:0] w_new;
    logic [7:0]       w_moves_inc;
    logic             w_press;
    logic             w_hit;
    logic             w_out_of_moves;
    logic             w_timeout;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int unsigned n);
        logic [2*WIDTH-1:0] d;
        d = {v, v} << (n % WIDTH);
        return d[2*WIDTH-1:WIDTH];
    endfunction

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_k_meta <= '0;
            r_k_sync <= '0;
            r_k_prev <= '0;
        end else begin
            r_k_meta <= K;
            r_k_sync <= r_k_meta;
            r_k_prev <= r_k_sync;
        end
    end

    // Rising edges of the synchronized keys, with the upper keys masked in easy mode
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < NKEYS; i++) begin
            w_valid[i] = r_k_sync[i] & ~r_k_prev[i] & ((i < 4) | DifMod);
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (w_valid[i]) w_sel = i[2:0];
        end
    end

    assign w_press        = (|w_valid) && (r_state == S_PLAY);
    assign w_rot          = DifMod ? {w_sel, 1'b0} : {1'b0, w_sel};
    assign w_opd          = rotl(PATTERN, 32'(w_rot));
    assign w_moves_inc    = r_moves + 8'd1;
    assign w_hit          = (w_new == TARGET);
    assign w_out_of_moves = (w_moves_inc == 8'(MAX_MOVES));

    always_comb begin
        case (r_op)
            2'd0:    w_new = r_led ^ w_opd;
            2'd1:    w_new = ~(r_led ^ w_opd);
            2'd2:    w_new = r_led | w_opd;
            default: w_new = ~(r_led | w_opd);
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_led   <= INIT;
            r_op    <= 2'd0;
            r_moves <= 8'd0;
        end else if (w_press) begin
            r_led   <= w_new;
            r_op    <= r_op + 2'd1;
            r_moves <= w_moves_inc;
        end
    end

`ifdef KEY_PUZZLE_TIMER_EN
    logic [15:0] r_time;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_time <= 16'(TIME_LIMIT);
        end else if (r_state == S_PLAY && r_time != 16'd0) begin
            r_time <= r_time - 16'd1;
        end
    end

    // The count hits zero on this edge
    assign w_timeout = (r_state == S_PLAY) && (r_time == 16'd1);
    assign time_left = r_time;
`else
    assign w_timeout = 1'b0;
    // Countdown compiled out; the limit only matters for the timed build
    assign time_left = 16'(TIME_LIMIT & 0);
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) r_state <= S_PLAY;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_PLAY: begin
                if (w_press && w_hit)               w_next = S_DEFUSED;
                else if (w_press && w_out_of_moves) w_next = S_FAILED;
                else if (w_timeout)                 w_next = S_FAILED;
            end
            default: w_next = r_state;
        endcase
    end

    always_comb begin
        isd  = (r_state == S_DEFUSED);
        fail = (r_state == S_FAILED);
    end

    assign LED   = r_led;
    assign op    = r_op;
    assign moves = r_moves;

endmodule

// File: tb/tb_key_puzzle_engine.sv
// Directed bench for key_puzzle_engine: several parameterisations driven by shared keys.
module tb_key_puzzle_engine;

    logic       CLK;
    logic       reset;
    logic [4:0] K;
    logic       DifMod;

    logic [7:0]  led_a, led_t, led_m, led_r;
    logic        isd_a, isd_t, isd_m, isd_r;
    logic        fail_a, fail_t, fail_m, fail_r;
    logic [1:0]  op_a, op_t, op_m, op_r;
    logic [7:0]  mv_a, mv_t, mv_m, mv_r;
    logic [15:0] tl_a, tl_t, tl_m, tl_r;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef KEY_PUZZLE_TIMER_EN
    localparam logic [15:0] TL_A_RST = 16'd1000;
`else
    localparam logic [15:0] TL_A_RST = 16'd0;
`endif

    key_puzzle_engine dut_a (
        .CLK(CLK), .reset(reset), .K(K), .DifMod(DifMod),
        .LED(led_a), .isd(isd_a), .fail(fail_a), .op(op_a), .moves(mv_a), .time_left(tl_a)
    );

    key_puzzle_engine #(.TARGET(8'h59)) dut_t (
        .CLK(CLK), .reset(reset), .K(K), .DifMod(DifMod),
        .LED(led_t), .isd(isd_t), .fail(fail_t), .op(op_t), .moves(mv_t), .time_left(tl_t)
    );

    key_puzzle_engine #(.MAX_MOVES(4)) dut_m (
        .CLK(CLK), .reset(reset), .K(K), .DifMod(DifMod),
        .LED(led_m), .isd(isd_m), .fail(fail_m), .op(op_m), .moves(mv_m), .time_left(tl_m)
    );

    key_puzzle_engine #(.TIME_LIMIT(20)) dut_r (
        .CLK(CLK), .reset(reset), .K(K), .DifMod(DifMod),
        .LED(led_r), .isd(isd_r), .fail(fail_r), .op(op_r), .moves(mv_r), .time_left(tl_r)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [4:0] m);
        @(negedge CLK);
        K = m;
        repeat (5) @(negedge CLK);
        K = '0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        K      = '0;
        DifMod = 1'b0;
        reset  = 1'b0;
        repeat (2) @(negedge CLK);

        chk("rst_led",  32'(led_a), 32'h5A);
        chk("rst_op",   32'(op_a),  32'h0);
        chk("rst_mv",   32'(mv_a),  32'h0);
        chk("rst_isd",  32'(isd_a), 32'h0);
        chk("rst_fail", 32'(fail_a), 32'h0);
        chk("rst_tl",   32'(tl_a),  32'(TL_A_RST));
        reset = 1'b1;
        @(negedge CLK);

        // Four presses in easy mode
        press(5'b00001);
        chk("p1_led", 32'(led_a), 32'h59); chk("p1_op", 32'(op_a), 32'h1); chk("p1_mv", 32'(mv_a), 32'd1);
        chk("t_isd",  32'(isd_t), 32'h1);  chk("t_led", 32'(led_t), 32'h59);
        press(5'b00010);
        chk("p2_led", 32'(led_a), 32'hA0); chk("p2_op", 32'(op_a), 32'h2); chk("p2_mv", 32'(mv_a), 32'd2);
        chk("t_led_frz", 32'(led_t), 32'h59); chk("t_mv_frz", 32'(mv_t), 32'd1);
        chk("t_op_frz",  32'(op_t),  32'h1);  chk("t_isd_hold", 32'(isd_t), 32'h1);
        chk("t_fail", 32'(fail_t), 32'h0);
        press(5'b00100);
        chk("p3_led", 32'(led_a), 32'hAC); chk("p3_op", 32'(op_a), 32'h3); chk("p3_mv", 32'(mv_a), 32'd3);
        chk("m_fail_early", 32'(fail_m), 32'h0);
        press(5'b01000);
        chk("p4_led", 32'(led_a), 32'h43); chk("p4_op", 32'(op_a), 32'h0); chk("p4_mv", 32'(mv_a), 32'd4);
        chk("m_fail", 32'(fail_m), 32'h1); chk("m_isd", 32'(isd_m), 32'h0);
        press(5'b00001);
        chk("m_led_frz", 32'(led_m), 32'h43); chk("m_mv_frz", 32'(mv_m), 32'd4);

        // Asynchronous reset, observed before any clock edge
        @(negedge CLK);
        reset = 1'b0;
        #1;
        chk("m_async_led",  32'(led_m), 32'h5A);
        chk("m_async_fail", 32'(fail_m), 32'h0);
        chk("t_async_isd",  32'(isd_t), 32'h0);
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);

        press(5'b10000);
        chk("k4_ignored_led", 32'(led_a), 32'h5A);
        chk("k4_ignored_mv",  32'(mv_a),  32'd0);
        DifMod = 1'b1;
        press(5'b00010);
        chk("hard_k1_led", 32'(led_a), 32'h56);
        DifMod = 1'b0;

        do_reset();
        press(5'b00101);
        chk("multi_led", 32'(led_a), 32'h59);
        chk("multi_mv",  32'(mv_a),  32'd1);

        // Update lands on the third rising edge after K rises
        do_reset();
        K = 5'b00001;
        repeat (2) @(posedge CLK);
        #1 chk("lat_edge2", 32'(led_a), 32'h5A);
        @(posedge CLK);
        #1 chk("lat_edge3", 32'(led_a), 32'h59);
        K = '0;
        repeat (4) @(negedge CLK);

        // Held key: one press only
        do_reset();
        K = 5'b00001;
        repeat (50) @(negedge CLK);
        K = '0;
        repeat (4) @(negedge CLK);
        chk("held_mv",  32'(mv_a),  32'd1);
        chk("held_led", 32'(led_a), 32'h59);

        // Key held through reset release is taken once afterwards
        @(negedge CLK);
        K = 5'b00001;
        reset = 1'b0;
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        repeat (6) @(negedge CLK);
        K = '0;
        repeat (4) @(negedge CLK);
        chk("thru_rst_mv", 32'(mv_a), 32'd1);

        // Countdown from 20 with no presses
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        repeat (19) @(posedge CLK);
`ifdef KEY_PUZZLE_TIMER_EN
        #1 chk("tmr_19_tl", 32'(tl_r), 32'd1);
        chk("tmr_19_fail", 32'(fail_r), 32'h0);
        @(posedge CLK);
        #1 chk("tmr_20_tl", 32'(tl_r), 32'd0);
        chk("tmr_20_fail", 32'(fail_r), 32'h1);
        chk("tmr_isd", 32'(isd_r), 32'h0);
`else
        @(posedge CLK);
        repeat (10) @(posedge CLK);
        #1 chk("notmr_tl", 32'(tl_r), 32'd0);
        chk("notmr_fail", 32'(fail_r), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
